// File: rtl/serial_alu_sequencer_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: operation codes,
// slice function selects and FSM state encoding.
// Imported by the slice, the sequencer and its bench.
package serial_alu_pkg;

  // Full 3-bit alu_op encodings: [2] = bnegate, [1:0] = function select.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Function-select field alone (alu_op[1:0]).
  localparam logic [1:0] FN_AND   = 2'b00;
  localparam logic [1:0] FN_OR    = 2'b01;
  localparam logic [1:0] FN_ARITH = 2'b10;
  localparam logic [1:0] FN_SLT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// serial ALU sequencer (slave): start/abort/op/operands in,
// busy/done/result/flags out.
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, abort, alu_op, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, abort, alu_op, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/serial_alu_sequencer_alu_bit_slice.sv
// One-bit ALU slice, purely combinational (zero latency, no backpressure).
// Ports: a, b, cin, alu_op in; r (bit result), cout, v (cin^cout, signed
// overflow when this is the MSB), set (sign corrected for overflow) out.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] alu_op,
  output logic       r,
  output logic       cout,
  output logic       v,
  output logic       set
);

  logic x;
  logic sum;

  always_comb begin
    x    = b ^ alu_op[2];
    sum  = a ^ x ^ cin;
    cout = (a & x) | (cin & (a ^ x));
    v    = cin ^ cout;
    // Sum sign XOR overflow gives the true sign of a-b, so SLT stays correct
    // when the subtraction wraps.
    set  = v ^ sum;
    r    = 1'b0;
    case (alu_op[1:0])
      FN_AND:   r = a & x;
      // With bnegate set, the OR encoding means NOR of the raw operands.
      FN_OR:    r = alu_op[2] ? ~(a | b) : (a | x);
      FN_ARITH: r = sum;
      FN_SLT:   r = 1'b0;
      default:  r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: drives one alu_bit_slice LSB first, one bit per clk.
// Latency: done pulses WIDTH edges after the accepting edge; busy in RUN and DONE.
// Backpressure: start is only taken in IDLE; starts while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low) and a slave-side serial_alu_sequencer_if
// carrying start/abort/alu_op/a/b in and busy/done/result/zero/overflow out.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_alu_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [2:0]       op_q,     op_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  // Holds the WIDTH-1 bits already produced; the slice supplies the MSB.
  logic [WIDTH-2:0] work_q,   work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;

  logic             slice_r;
  logic             slice_cout;
  logic             slice_v;
  logic             slice_set;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] final_res;

  alu_bit_slice u_slice (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .cin    (carry_q),
    .alu_op (op_q),
    .r      (slice_r),
    .cout   (slice_cout),
    .v      (slice_v),
    .set    (slice_set)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    shift_in  = {slice_r, work_q};
    final_res = (op_q[1:0] == FN_SLT) ? {{(WIDTH-1){1'b0}}, slice_set} : shift_in;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.alu_op;
          cnt_d   = '0;
          carry_d = bus.alu_op[2];
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins even on the MSB step: nothing is committed.
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          a_sh_d  = a_sh_q >> 1;
          b_sh_d  = b_sh_q >> 1;
          work_d  = shift_in[WIDTH-1:1];
          carry_d = slice_cout;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            result_d = final_res;
            zero_d   = (final_res == '0);
            ovf_d    = (op_q[1:0] == FN_ARITH) ? slice_v : 1'b0;
            cnt_d    = '0;
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: expected results come from a
// behavioural word-level model, queued at start and popped at done.
module tb_serial_alu_sequencer;
  import serial_alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  exp_t sb[$];
  logic [W-1:0] last_res;

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    logic v;
    v = 1'b0;
    r = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: r = '0;
    endcase
    e.res = r;
    e.z   = (r == '0);
    e.v   = v;
    return e;
  endfunction

  // Launch one op; pulse_at >= 1 fires a stray start (other operands) at that RUN cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int pulse_at);
    exp_t e;
    int   cyc;
    int   extra;
    logic got;
    logic busy_ok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.a      = a;
    bus.b      = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    // Operand changes after acceptance must not matter.
    bus.start  = 1'b0;
    bus.a      = ~a;
    bus.b      = a ^ b ^ 32'h5A5A_0F0F;
    bus.alu_op = ~op;
    cyc = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < W + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) got = 1'b1;
      else begin
        if (!bus.busy) busy_ok = 1'b0;
        if (cyc == pulse_at) begin
          bus.start = 1'b1;
          bus.a = 32'h1234_5678;
        end
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'(W));
    check({tag, "_busy_run"}, {63'b0, busy_ok}, 64'd1);
    e = sb.pop_front();
    if (got) begin
      check({tag, "_result"}, {32'b0, bus.result}, {32'b0, e.res});
      check({tag, "_zero"}, {63'b0, bus.zero}, {63'b0, e.z});
      check({tag, "_overflow"}, {63'b0, bus.overflow}, {63'b0, e.v});
      check({tag, "_busy_done"}, {63'b0, bus.busy}, 64'd1);
      last_res = e.res;
      // Start held through DONE must be ignored.
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check({tag, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
      check({tag, "_idle_after"}, {63'b0, bus.busy}, 64'd0);
      if (pulse_at >= 0) begin
        extra = 0;
        repeat (W + 4) begin
          @(posedge clk);
          #1;
          if (bus.done) extra++;
        end
        check({tag, "_no_second_done"}, 64'(extra), 64'd0);
      end
    end
  endtask

  initial begin
    int ndone;
    int abort_pts[2];
    logic [2:0] ops[6];
    total = 0;
    passed = 0;
    last_res = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.alu_op = '0;
    bus.a = '0;
    bus.b = '0;
    #23;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_result", {32'b0, bus.result}, 64'd0);
    check("rst_zero", {63'b0, bus.zero}, 64'd0);
    check("rst_overflow", {63'b0, bus.overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, -1);
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, -1);
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, -1);
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    run_op("slt_vcorr", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, -1);
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
    run_op("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
    run_op("nor", OP_NOR, 32'h0, 32'h0, -1);
    run_op("add_start_ign", OP_ADD, 32'h0001_0002, 32'h0003_0004, 5);

    // Abort mid-run and on the MSB step: no done, result unchanged.
    abort_pts[0] = 10;
    abort_pts[1] = W - 1;
    foreach (abort_pts[k]) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.alu_op = OP_ADD;
      bus.a = 32'h0000_0001;
      bus.b = 32'h0000_0002;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (abort_pts[k]) @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      check("abort_idle", {63'b0, bus.busy}, 64'd0);
      ndone = 0;
      repeat (W + 4) begin
        @(posedge clk);
        #1;
        if (bus.done) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      check("abort_result_hold", {32'b0, bus.result}, {32'b0, last_res});
      run_op("after_abort", OP_ADD, 32'd3, 32'd4, -1);
    end

    // Async reset mid-run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_op = OP_SUB;
    bus.a = 32'd100;
    bus.b = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, bus.busy}, 64'd0);
    check("arst_done", {63'b0, bus.done}, 64'd0);
    check("arst_result", {32'b0, bus.result}, 64'd0);
    check("arst_zero", {63'b0, bus.zero}, 64'd0);
    check("arst_overflow", {63'b0, bus.overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    run_op("after_rst", OP_SUB, 32'd100, 32'd1, -1);

    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT};
    for (int i = 0; i < 12; i++) begin
      run_op("rand", ops[i % 6], $urandom, $urandom, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
